// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_unit_if
// Brief   : Instruction-memory and consumer handshake bundle for the fetch unit.
// Revision: 1.0
// ============================================================================
interface instr_fetch_unit_if #(
    parameter int XLEN = 32
);
    // Instruction memory side
    logic            imemReq;
    logic [XLEN-1:0] imemAddr;
    logic            imemValid;
    logic [31:0]     imemRdata;

    // Decoder / datapath side
    logic [31:0]     instr;
    logic [XLEN-1:0] instrPC;
    logic            instrValid;
    logic            instrReady;
    logic            pcSrc;
    logic [XLEN-1:0] pcTarget;

    // Status
    logic            fetchFault;
    logic [31:0]     fetchCount;

    // The fetch unit drives the bus
    modport master (
        output imemReq,
        output imemAddr,
        input  imemValid,
        input  imemRdata,
        output instr,
        output instrPC,
        output instrValid,
        input  instrReady,
        input  pcSrc,
        input  pcTarget,
        output fetchFault,
        output fetchCount
    );

    // Memory and core environment
    modport slave (
        input  imemReq,
        input  imemAddr,
        output imemValid,
        output imemRdata,
        input  instr,
        input  instrPC,
        input  instrValid,
        output instrReady,
        output pcSrc,
        output pcTarget,
        input  fetchFault,
        input  fetchCount
    );
endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : instr_fetch_unit
// Brief   : PC owner and single-outstanding instruction fetcher with a held
//           instruction handshake towards decode.
// Revision: 1.0
// ============================================================================
module instr_fetch_unit #(
    parameter int               XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_PC  = '0,
    parameter logic [31:0]      NOP_INSTR = 32'h0000_0013
) (
    input  wire logic                clk,
    input  wire logic                rstN,
    instr_fetch_unit_if.master       bus
);

    localparam logic [1:0] c_st_boot  = 2'd0;
    localparam logic [1:0] c_st_fetch = 2'd1;
    localparam logic [1:0] c_st_hold  = 2'd2;
    localparam logic [1:0] c_st_fault = 2'd3;

    localparam logic [XLEN-1:0] c_pc_step = XLEN'(4);

    logic [1:0]      r_state;
    logic [1:0]      w_state_next;

    logic            r_imem_req;
    logic [XLEN-1:0] r_imem_addr;
    logic [31:0]     r_instr;
    logic [XLEN-1:0] r_instr_pc;
    logic            r_instr_valid;
    logic            r_fetch_fault;
    logic [31:0]     r_fetch_count;

    logic            w_imem_req_n;
    logic [XLEN-1:0] w_imem_addr_n;
    logic [31:0]     w_instr_n;
    logic [XLEN-1:0] w_instr_pc_n;
    logic            w_instr_valid_n;
    logic            w_fetch_fault_n;
    logic [31:0]     w_fetch_count_n;

    logic [XLEN-1:0] w_next_pc;
    logic            w_misaligned;
    logic            w_resp;
    logic            w_retire;

    // Redirect choice is only meaningful in the retire cycle; elsewhere it is unused.
    assign w_next_pc    = bus.pcSrc ? bus.pcTarget : (r_instr_pc + c_pc_step);
    assign w_misaligned = |w_next_pc[1:0];
    assign w_resp       = (r_state == c_st_fetch) && bus.imemValid;
    assign w_retire     = (r_state == c_st_hold)  && bus.instrReady;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state <= c_st_boot;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_boot:  w_state_next = c_st_fetch;
            c_st_fetch: begin
                if (w_resp) begin
                    w_state_next = c_st_hold;
                end
            end
            c_st_hold: begin
                if (w_retire) begin
                    w_state_next = w_misaligned ? c_st_fault : c_st_fetch;
                end
            end
            c_st_fault: w_state_next = c_st_fault;
            default:    w_state_next = c_st_boot;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic: next values of the registered outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_imem_req_n    = r_imem_req;
        w_imem_addr_n   = r_imem_addr;
        w_instr_n       = r_instr;
        w_instr_pc_n    = r_instr_pc;
        w_instr_valid_n = r_instr_valid;
        w_fetch_fault_n = r_fetch_fault;
        w_fetch_count_n = r_fetch_count;
        case (r_state)
            c_st_boot: begin
                w_imem_req_n  = 1'b1;
                w_imem_addr_n = RESET_PC;
            end
            c_st_fetch: begin
                if (w_resp) begin
                    w_instr_n       = bus.imemRdata;
                    w_instr_pc_n    = r_imem_addr;
                    w_instr_valid_n = 1'b1;
                    w_imem_req_n    = 1'b0;
                end
            end
            c_st_hold: begin
                if (w_retire) begin
                    w_fetch_count_n = r_fetch_count + 32'd1;
                    w_instr_valid_n = 1'b0;
                    w_instr_n       = NOP_INSTR;
                    if (w_misaligned) begin
                        w_fetch_fault_n = 1'b1;
                    end else begin
                        w_imem_addr_n = w_next_pc;
                        w_imem_req_n  = 1'b1;
                    end
                end
            end
            c_st_fault: begin
                w_imem_req_n    = 1'b0;
                w_instr_valid_n = 1'b0;
            end
            default: begin
                w_imem_req_n    = 1'b0;
                w_instr_valid_n = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_imem_req    <= 1'b0;
            r_imem_addr   <= RESET_PC;
            r_instr       <= NOP_INSTR;
            r_instr_pc    <= RESET_PC;
            r_instr_valid <= 1'b0;
            r_fetch_fault <= 1'b0;
            r_fetch_count <= '0;
        end else begin
            r_imem_req    <= w_imem_req_n;
            r_imem_addr   <= w_imem_addr_n;
            r_instr       <= w_instr_n;
            r_instr_pc    <= w_instr_pc_n;
            r_instr_valid <= w_instr_valid_n;
            r_fetch_fault <= w_fetch_fault_n;
            r_fetch_count <= w_fetch_count_n;
        end
    end

    assign bus.imemReq    = r_imem_req;
    assign bus.imemAddr   = r_imem_addr;
    assign bus.instr      = r_instr;
    assign bus.instrPC    = r_instr_pc;
    assign bus.instrValid = r_instr_valid;
    assign bus.fetchFault = r_fetch_fault;
    assign bus.fetchCount = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_instr_fetch_unit
// Brief   : Directed self-checking bench for instr_fetch_unit.
// Revision: 1.0
// ============================================================================
module tb_instr_fetch_unit;

    localparam logic [31:0] c_nop = 32'h0000_0013;

    logic clk;
    logic rstN;
    int   errors;
    int   checks;
    logic [31:0] exp_count;

    instr_fetch_unit_if #(.XLEN(32)) bus ();

    instr_fetch_unit #(
        .XLEN      (32),
        .RESET_PC  (32'h0000_0000),
        .NOP_INSTR (c_nop)
    ) dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Request and held-valid must never overlap while out of reset.
    always @(negedge clk) begin
        if (rstN === 1'b1) begin
            checks = checks + 1;
            if ((bus.instrValid & bus.imemReq) !== 1'b0) begin
                errors = errors + 1;
                $display("FAIL overlap: instrValid=%b imemReq=%b required not both 1", bus.instrValid, bus.imemReq);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a + 32'h0050_0093;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One-cycle zero-wait response to the current request.
    task automatic respond();
        bus.imemValid = 1'b1;
        bus.imemRdata = mem_word(bus.imemAddr);
        step();
        bus.imemValid = 1'b0;
        bus.imemRdata = 32'hDEAD_BEEF;
    endtask

    task automatic retire(input logic src, input logic [31:0] tgt);
        bus.instrReady = 1'b1;
        bus.pcSrc      = src;
        bus.pcTarget   = tgt;
        step();
        bus.instrReady = 1'b0;
        bus.pcSrc      = 1'b0;
        bus.pcTarget   = 32'h0;
        exp_count      = exp_count + 32'd1;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        bus.imemValid = 1'b0; bus.imemRdata = 32'h0;
        bus.instrReady = 1'b0; bus.pcSrc = 1'b0; bus.pcTarget = 32'h0;
        exp_count = 32'd0;
        step(); step();
        checks = checks + 1;
        if ({bus.imemReq, bus.imemAddr, bus.instr, bus.instrPC, bus.instrValid, bus.fetchFault, bus.fetchCount}
            !== {1'b0, 32'h0, c_nop, 32'h0, 1'b0, 1'b0, 32'h0}) begin
            errors = errors + 1;
            $display("FAIL reset_values: req=%b addr=%h instr=%h pc=%h v=%b f=%b cnt=%0d required 0/0/%h/0/0/0/0",
                     bus.imemReq, bus.imemAddr, bus.instr, bus.instrPC, bus.instrValid, bus.fetchFault, bus.fetchCount, c_nop);
        end
        rstN = 1'b1;
        step();
        checks = checks + 1;
        if ({bus.imemReq, bus.imemAddr, bus.instrValid} !== {1'b1, 32'h0, 1'b0}) begin
            errors = errors + 1;
            $display("FAIL boot_exit: req=%b addr=%h v=%b required 1/00000000/0", bus.imemReq, bus.imemAddr, bus.instrValid);
        end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            checks = checks + 1;
            if ({bus.imemReq, bus.imemAddr} !== {1'b1, 32'(4 * i)}) begin
                errors = errors + 1;
                $display("FAIL seq_req[%0d]: req=%b addr=%h required 1/%h", i, bus.imemReq, bus.imemAddr, 32'(4 * i));
            end
            respond();
            checks = checks + 1;
            if ({bus.instrValid, bus.imemReq, bus.instr, bus.instrPC} !== {1'b1, 1'b0, mem_word(32'(4 * i)), 32'(4 * i)}) begin
                errors = errors + 1;
                $display("FAIL seq_hold[%0d]: v=%b req=%b instr=%h pc=%h required 1/0/%h/%h",
                         i, bus.instrValid, bus.imemReq, bus.instr, bus.instrPC, mem_word(32'(4 * i)), 32'(4 * i));
            end
            retire(1'b0, 32'h0);
            checks = checks + 1;
            if ({bus.instrValid, bus.instr} !== {1'b0, c_nop}) begin
                errors = errors + 1;
                $display("FAIL seq_retire[%0d]: v=%b instr=%h required 0/%h", i, bus.instrValid, bus.instr, c_nop);
            end
        end
        checks = checks + 1;
        if (bus.fetchCount !== 32'd3) begin
            errors = errors + 1;
            $display("FAIL seq_count: fetchCount=%0d required 3", bus.fetchCount);
        end
    endtask

    task automatic test_branch();
        // Redirect attempt while waiting on memory must not move the address.
        bus.pcSrc = 1'b1; bus.pcTarget = 32'h80;
        step();
        bus.pcSrc = 1'b0; bus.pcTarget = 32'h0;
        checks = checks + 1;
        if ({bus.imemReq, bus.imemAddr} !== {1'b1, 32'hC}) begin
            errors = errors + 1;
            $display("FAIL pcsrc_in_fetch: req=%b addr=%h required 1/0000000c", bus.imemReq, bus.imemAddr);
        end
        respond();
        bus.pcSrc = 1'b1; bus.pcTarget = 32'h80;
        step();
        checks = checks + 1;
        if ({bus.instrValid, bus.imemReq, bus.instrPC} !== {1'b1, 1'b0, 32'hC}) begin
            errors = errors + 1;
            $display("FAIL pcsrc_in_stall: v=%b req=%b pc=%h required 1/0/0000000c", bus.instrValid, bus.imemReq, bus.instrPC);
        end
        retire(1'b0, 32'h80);
        checks = checks + 1;
        if (bus.imemAddr !== 32'h10) begin
            errors = errors + 1;
            $display("FAIL stale_pcsrc: addr=%h required 00000010", bus.imemAddr);
        end
        respond();
        retire(1'b1, 32'h40);
        checks = checks + 1;
        if ({bus.imemReq, bus.imemAddr} !== {1'b1, 32'h40}) begin
            errors = errors + 1;
            $display("FAIL branch_addr: req=%b addr=%h required 1/00000040", bus.imemReq, bus.imemAddr);
        end
        respond();
        checks = checks + 1;
        if ({bus.instrPC, bus.instr} !== {32'h40, mem_word(32'h40)}) begin
            errors = errors + 1;
            $display("FAIL branch_pc: pc=%h instr=%h required 00000040/%h", bus.instrPC, bus.instr, mem_word(32'h40));
        end
        retire(1'b0, 32'h0);
        checks = checks + 1;
        if (bus.imemAddr !== 32'h44) begin
            errors = errors + 1;
            $display("FAIL after_branch: addr=%h required 00000044", bus.imemAddr);
        end
    endtask

    task automatic test_stall();
        for (int w = 0; w < 3; w++) begin
            step();
            checks = checks + 1;
            if ({bus.imemReq, bus.imemAddr, bus.instrValid} !== {1'b1, 32'h44, 1'b0}) begin
                errors = errors + 1;
                $display("FAIL wait_state[%0d]: req=%b addr=%h v=%b required 1/00000044/0", w, bus.imemReq, bus.imemAddr, bus.instrValid);
            end
        end
        bus.imemValid = 1'b1; bus.imemRdata = 32'h0050_0093;
        step();
        bus.imemValid = 1'b0;
        for (int s = 0; s < 5; s++) begin
            checks = checks + 1;
            if ({bus.instr, bus.instrPC, bus.instrValid, bus.imemReq} !== {32'h0050_0093, 32'h44, 1'b1, 1'b0}) begin
                errors = errors + 1;
                $display("FAIL stall[%0d]: instr=%h pc=%h v=%b req=%b required 00500093/00000044/1/0",
                         s, bus.instr, bus.instrPC, bus.instrValid, bus.imemReq);
            end
            step();
        end
        retire(1'b0, 32'h0);
        checks = checks + 1;
        if (bus.imemAddr !== 32'h48) begin
            errors = errors + 1;
            $display("FAIL after_stall: addr=%h required 00000048", bus.imemAddr);
        end
    endtask

    task automatic test_wrap();
        respond();
        retire(1'b1, 32'hFFFF_FFFC);
        respond();
        checks = checks + 1;
        if (bus.instrPC !== 32'hFFFF_FFFC) begin
            errors = errors + 1;
            $display("FAIL top_pc: pc=%h required fffffffc", bus.instrPC);
        end
        retire(1'b0, 32'h0);
        checks = checks + 1;
        if ({bus.imemReq, bus.imemAddr} !== {1'b1, 32'h0}) begin
            errors = errors + 1;
            $display("FAIL pc_wrap: req=%b addr=%h required 1/00000000", bus.imemReq, bus.imemAddr);
        end
        checks = checks + 1;
        if (bus.fetchCount !== exp_count) begin
            errors = errors + 1;
            $display("FAIL count: fetchCount=%0d required %0d", bus.fetchCount, exp_count);
        end
    endtask

    task automatic test_fault();
        respond();
        retire(1'b1, 32'h42);
        checks = checks + 1;
        if ({bus.fetchFault, bus.imemReq, bus.instrValid, bus.fetchCount} !== {1'b1, 1'b0, 1'b0, exp_count}) begin
            errors = errors + 1;
            $display("FAIL fault_entry: f=%b req=%b v=%b cnt=%0d required 1/0/0/%0d",
                     bus.fetchFault, bus.imemReq, bus.instrValid, bus.fetchCount, exp_count);
        end
        bus.imemValid = 1'b1; bus.imemRdata = 32'h1234_5678; bus.instrReady = 1'b1;
        for (int c = 0; c < 20; c++) begin
            step();
            checks = checks + 1;
            if ({bus.fetchFault, bus.imemReq, bus.instrValid} !== 3'b100) begin
                errors = errors + 1;
                $display("FAIL fault_hold[%0d]: f=%b req=%b v=%b required 1/0/0", c, bus.fetchFault, bus.imemReq, bus.instrValid);
            end
        end
        bus.imemValid = 1'b0; bus.instrReady = 1'b0;
        rstN = 1'b0;
        #2;
        checks = checks + 1;
        if ({bus.fetchFault, bus.fetchCount, bus.imemAddr} !== {1'b0, 32'h0, 32'h0}) begin
            errors = errors + 1;
            $display("FAIL fault_reset: f=%b cnt=%0d addr=%h required 0/0/00000000", bus.fetchFault, bus.fetchCount, bus.imemAddr);
        end
        exp_count = 32'd0;
        step();
        rstN = 1'b1;
        step();
        checks = checks + 1;
        if ({bus.imemReq, bus.imemAddr} !== {1'b1, 32'h0}) begin
            errors = errors + 1;
            $display("FAIL refetch: req=%b addr=%h required 1/00000000", bus.imemReq, bus.imemAddr);
        end
    endtask

    task automatic test_reset_midfetch();
        respond();
        retire(1'b0, 32'h0);
        step();
        // Reset lands between edges, with a response arriving at the same time.
        #2;
        rstN = 1'b0;
        bus.imemValid = 1'b1; bus.imemRdata = 32'hCAFE_0001;
        #1;
        checks = checks + 1;
        if ({bus.imemReq, bus.imemAddr, bus.instr, bus.instrPC, bus.instrValid, bus.fetchCount}
            !== {1'b0, 32'h0, c_nop, 32'h0, 1'b0, 32'h0}) begin
            errors = errors + 1;
            $display("FAIL async_reset: req=%b addr=%h instr=%h pc=%h v=%b cnt=%0d required 0/0/%h/0/0/0",
                     bus.imemReq, bus.imemAddr, bus.instr, bus.instrPC, bus.instrValid, bus.fetchCount, c_nop);
        end
        step(); step();
        rstN = 1'b1;
        step();
        checks = checks + 1;
        if ({bus.imemReq, bus.imemAddr, bus.instrValid, bus.instr} !== {1'b1, 32'h0, 1'b0, c_nop}) begin
            errors = errors + 1;
            $display("FAIL late_resp_ignored: req=%b addr=%h v=%b instr=%h required 1/0/0/%h",
                     bus.imemReq, bus.imemAddr, bus.instrValid, bus.instr, c_nop);
        end
        bus.imemRdata = mem_word(32'h0);
        step();
        bus.imemValid = 1'b0;
        checks = checks + 1;
        if ({bus.instrValid, bus.instr, bus.instrPC} !== {1'b1, mem_word(32'h0), 32'h0}) begin
            errors = errors + 1;
            $display("FAIL first_after_reset: v=%b instr=%h pc=%h required 1/%h/00000000",
                     bus.instrValid, bus.instr, bus.instrPC, mem_word(32'h0));
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_sequential();
        test_branch();
        test_stall();
        test_wrap();
        test_fault();
        test_reset_midfetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
